// File: rtl/ulx3s_reset_sequencer.sv
// ulx3s_reset_sequencer
// Orders reset release for the 50 MHz memory clock domain downstream of the
// board PLL: the BRAM memory controller leaves reset first, the CPU second.
// Any loss of PLL lock or a button press drops both resets again and restarts
// the whole sequence. Lock losses seen after qualification are counted.
//
// Ports:
//   clock           in   50 MHz clkMEMORY from the PLL
//   reset_n         in   synchronous active-low reset
//   pll_locked      in   PLL lock, asynchronous to clock
//   btn_reset       in   board reset button, active-high, asynchronous
//   mem_reset       out  active-high memory controller reset
//   cpu_reset       out  active-high CPU reset
//   ready           out  high only while running
//   lock_loss_count out  saturating count of lock losses
//   seq_state       out  current sequencer state, for debug
module ulx3s_reset_sequencer #(
  parameter int LOCK_FILTER = 16,
  parameter int MEM_HOLD    = 64,
  parameter int CPU_HOLD    = 256,
  parameter int CNT_W       = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       btn_reset,
  output logic       mem_reset,
  output logic       cpu_reset,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic [1:0] seq_state
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_MEM  = 2'd1,
    S_CPU  = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  // Terminal counts: the counter starts at zero, so the last cycle is N-1.
  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] MEM_LAST    = CNT_W'(MEM_HOLD - 1);
  localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             lock_meta_r;
  logic             lock_s;
  logic             btn_meta_r;
  logic             btn_s;
  logic             qual_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [7:0]       loss_r;
  logic [7:0]       loss_nxt_s;
  logic             mem_reset_r;
  logic             cpu_reset_r;
  logic             ready_r;

  // Two-flop synchronizers for the asynchronous lock and button inputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lock_meta_r <= 1'b0;
      lock_s      <= 1'b0;
      btn_meta_r  <= 1'b0;
      btn_s       <= 1'b0;
    end else begin
      lock_meta_r <= pll_locked;
      lock_s      <= lock_meta_r;
      btn_meta_r  <= btn_reset;
      btn_s       <= btn_meta_r;
    end
  end

  // A cycle "qualifies" only when lock is good and the button is released.
  assign qual_s = lock_s & ~btn_s;

  // Next-state, counter and lock-loss counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    loss_nxt_s  = loss_r;
    case (state_r)
      S_WAIT: begin
        if (qual_s) begin
          if (cnt_r == FILTER_LAST) begin
            state_nxt_s = S_MEM;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nxt_s = CNT_ZERO;
        end
      end
      S_MEM, S_CPU, S_RUN: begin
        if (!qual_s) begin
          // Abort wins over any hold expiry on the same edge.
          state_nxt_s = S_WAIT;
          cnt_nxt_s   = CNT_ZERO;
          if (!lock_s && (loss_r != 8'hFF)) begin
            loss_nxt_s = loss_r + 8'd1;
          end else begin
            loss_nxt_s = loss_r;
          end
        end else if (state_r == S_MEM) begin
          if (cnt_r == MEM_LAST) begin
            state_nxt_s = S_CPU;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else if (state_r == S_CPU) begin
          if (cnt_r == CPU_LAST) begin
            state_nxt_s = S_RUN;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          // Running: hold until an abort.
          state_nxt_s = S_RUN;
          cnt_nxt_s   = cnt_r;
        end
      end
      default: begin
        state_nxt_s = S_WAIT;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they move on the same edge as seq_state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= S_WAIT;
      cnt_r       <= CNT_ZERO;
      loss_r      <= 8'd0;
      mem_reset_r <= 1'b1;
      cpu_reset_r <= 1'b1;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      loss_r      <= loss_nxt_s;
      mem_reset_r <= (state_nxt_s == S_WAIT) || (state_nxt_s == S_MEM);
      cpu_reset_r <= (state_nxt_s != S_RUN);
      ready_r     <= (state_nxt_s == S_RUN);
    end
  end

  assign mem_reset       = mem_reset_r;
  assign cpu_reset       = cpu_reset_r;
  assign ready           = ready_r;
  assign lock_loss_count = loss_r;
  assign seq_state       = state_r;

endmodule

// File: tb/tb_ulx3s_reset_sequencer.sv
// Testbench for ulx3s_reset_sequencer.
// dut_a uses the default timing and is driven from a vector table plus
// hand-written corner sequences. dut_b uses short holds and is driven with
// random stimulus against a reference model that reasons about how long
// the synchronized inputs have been continuously "good".
module tb_ulx3s_reset_sequencer;

  localparam int BF = 2;
  localparam int BM = 3;
  localparam int BC = 4;

  logic       clock = 1'b0;
  logic       a_rst_n, a_lock, a_btn;
  logic       a_mem, a_cpu, a_rdy;
  logic [7:0] a_cnt;
  logic [1:0] a_st;
  logic       b_rst_n, b_lock, b_btn;
  logic       b_mem, b_cpu, b_rdy;
  logic [7:0] b_cnt;
  logic [1:0] b_st;

  int total = 0;
  int bad   = 0;

  // Reference model state for dut_b.
  int m_len;
  int m_cnt;
  bit m_l1, m_l2, m_b1, m_b2;

  always #5 clock = ~clock;

  ulx3s_reset_sequencer dut_a (
    .clock(clock), .reset_n(a_rst_n), .pll_locked(a_lock), .btn_reset(a_btn),
    .mem_reset(a_mem), .cpu_reset(a_cpu), .ready(a_rdy),
    .lock_loss_count(a_cnt), .seq_state(a_st)
  );

  ulx3s_reset_sequencer #(.LOCK_FILTER(BF), .MEM_HOLD(BM), .CPU_HOLD(BC), .CNT_W(4)) dut_b (
    .clock(clock), .reset_n(b_rst_n), .pll_locked(b_lock), .btn_reset(b_btn),
    .mem_reset(b_mem), .cpu_reset(b_cpu), .ready(b_rdy),
    .lock_loss_count(b_cnt), .seq_state(b_st)
  );

  typedef struct {
    string      name;
    int         n;
    logic       rst_n;
    logic       lock;
    logic       btn;
    logic [1:0] st;
    logic       mem;
    logic       cpu;
    logic       rdy;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic tick_a(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_a(input string name, input logic [1:0] st, input logic mem,
                         input logic cpu, input logic rdy, input logic [7:0] cnt);
    total++;
    if ({a_st, a_mem, a_cpu, a_rdy, a_cnt} !== {st, mem, cpu, rdy, cnt}) begin
      bad++;
      $display("FAIL %s: got st=%0d mem=%0b cpu=%0b rdy=%0b cnt=%0d want st=%0d mem=%0b cpu=%0b rdy=%0b cnt=%0d",
               name, a_st, a_mem, a_cpu, a_rdy, a_cnt, st, mem, cpu, rdy, cnt);
    end
  endtask

  // One clock of dut_b with the reference model stepped alongside.
  task automatic step_b(input bit r, input bit l, input bit bt);
    int est;
    b_rst_n = r;
    b_lock  = l;
    b_btn   = bt;
    @(posedge clock);
    if (!r) begin
      m_len = 0; m_cnt = 0;
      m_l1 = 1'b0; m_l2 = 1'b0; m_b1 = 1'b0; m_b2 = 1'b0;
    end else begin
      if (m_l2 && !m_b2) begin
        if (m_len < 100000) m_len++;
      end else begin
        // Lock loss counts only if we had already left the waiting phase.
        if (!m_l2 && m_len >= BF && m_cnt < 255) m_cnt++;
        m_len = 0;
      end
      m_l2 = m_l1; m_l1 = l;
      m_b2 = m_b1; m_b1 = bt;
    end
    if (m_len < BF) est = 0;
    else if (m_len < BF + BM) est = 1;
    else if (m_len < BF + BM + BC) est = 2;
    else est = 3;
    #1;
    total++;
    if ({b_st, b_mem, b_cpu, b_rdy, b_cnt} !==
        {est[1:0], (est < 2), (est < 3), (est == 3), m_cnt[7:0]}) begin
      bad++;
      $display("FAIL model_b: got st=%0d mem=%0b cpu=%0b rdy=%0b cnt=%0d want st=%0d cnt=%0d",
               b_st, b_mem, b_cpu, b_rdy, b_cnt, est, m_cnt);
    end
  endtask

  initial begin
    tbl[0]  = '{"reset",        4, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[1]  = '{"filter_e17",  17, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{"mem_e18",      1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{"mem_e81",     63, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{"cpu_e82",      1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{"cpu_e337",   255, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{"run_e338",     1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[7]  = '{"loss_k",       1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[8]  = '{"loss_k1",      1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[9]  = '{"loss_k2",      1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[10] = '{"relock_e337",337, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[11] = '{"relock_e338",  1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 8'd1};

    b_rst_n = 1'b0; b_lock = 1'b0; b_btn = 1'b0;

    // Table: clean power-up, lock loss in run, relock.
    for (int i = 0; i < 12; i++) begin
      a_rst_n = tbl[i].rst_n;
      a_lock  = tbl[i].lock;
      a_btn   = tbl[i].btn;
      tick_a(tbl[i].n);
      check_a(tbl[i].name, tbl[i].st, tbl[i].mem, tbl[i].cpu, tbl[i].rdy, tbl[i].cnt);
    end

    // Second lock loss, relock into the CPU phase, then reset mid-operation.
    a_lock = 1'b0; tick_a(1); a_lock = 1'b1; tick_a(2);
    check_a("loss2", 2'd0, 1'b1, 1'b1, 1'b0, 8'd2);
    tick_a(98);
    check_a("loss2_cpu", 2'd2, 1'b0, 1'b1, 1'b0, 8'd2);
    a_rst_n = 1'b0; tick_a(1);
    check_a("midop_reset", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
    a_rst_n = 1'b1;

    // Lock glitch during qualification restarts the filter.
    a_rst_n = 1'b0; a_lock = 1'b0; tick_a(4);
    a_rst_n = 1'b1; a_lock = 1'b1; tick_a(9);
    a_lock = 1'b0; tick_a(1);
    a_lock = 1'b1; tick_a(8);
    check_a("glitch_e18", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
    tick_a(9);
    check_a("glitch_e27", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
    tick_a(1);
    check_a("glitch_e28", 2'd1, 1'b1, 1'b1, 1'b0, 8'd0);
    tick_a(63);
    check_a("glitch_e91", 2'd1, 1'b1, 1'b1, 1'b0, 8'd0);
    tick_a(1);
    check_a("glitch_e92", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);

    // Button pulse in the CPU phase: abort without counting, then restart.
    a_btn = 1'b1; tick_a(2);
    check_a("btn_e94", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    tick_a(1);
    a_btn = 1'b0;
    check_a("btn_e95", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
    tick_a(17);
    check_a("btn_e112", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
    tick_a(1);
    check_a("btn_e113", 2'd1, 1'b1, 1'b1, 1'b0, 8'd0);
    tick_a(319);
    check_a("btn_e432", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    tick_a(1);
    check_a("btn_e433", 2'd3, 1'b0, 1'b0, 1'b1, 8'd0);

    // Randomized stimulus on dut_b against the reference model.
    repeat (3) step_b(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step_b(($urandom_range(0, 199) != 0), ($urandom_range(0, 29) != 0),
             ($urandom_range(0, 49) == 0));
    end

    // Saturation: 300 lock losses from the running state.
    step_b(1'b0, 1'b0, 1'b0);
    for (int ev = 0; ev < 300; ev++) begin
      repeat (12) step_b(1'b1, 1'b1, 1'b0);
      repeat (3) step_b(1'b1, 1'b0, 1'b0);
    end
    total++;
    if (b_cnt !== 8'd255) begin
      bad++;
      $display("FAIL saturate: got cnt=%0d want 255", b_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
